dm_sub: RTL
===========

Name: dm_sub

Overview:
- Parametrised data-memory unit replacing the fixed 4 KB word memory with its single byte-mode flag.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Detects misaligned accesses and uses a req/ready handshake with configurable access latency, so the multi-cycle controller can stall on slow memory.
- Sits between the ALU-out register (address), the B register (store data) and the memory-data register (load result).

Parameters:
- ADDR_W, 12, byte-address width; capacity is 2**ADDR_W bytes, organised as 2**(ADDR_W-2) 32-bit words. Must be at least 3.
- LAT, 1, cycles from request accept to the ready pulse. Must be at least 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = store, 0 = load; captured on accept.
- size  input  2  access size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- sext  input  1  load extension: 1 = sign-extend, 0 = zero-extend; ignored for word and store accesses.
- addr  input  ADDR_W  byte address; captured on accept.
- din  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- ready  output  1  one-cycle pulse marking access completion.
- dout  output  32  load result; valid from the ready pulse and held until the next accept.
- busy  output  1  high from the cycle after accept through the ready cycle.
- misalign  output  1  pulses together with ready when the completed access was misaligned.

Behaviour:
- Reset: FSM goes to IDLE; ready=0, busy=0, misalign=0, dout=0, latency counter=0. Memory contents are not cleared.
- FSM has states IDLE, WAIT, DONE.
- IDLE:
  - With req=1 at a clock edge, the request is accepted: capture we, size, sext, addr and din; load counter with LAT-1; go to WAIT.
  - With req=0, stay in IDLE.
- WAIT:
  - busy=1.
  - If counter is 0, go to DONE; otherwise decrement the counter.
- DONE (lasts one cycle):
  - ready=1, busy=1.
  - Perform the array write if the access is a store, or drive dout if it is a load.
  - Return to IDLE.
- Latency: accept at edge k gives ready high during the cycle after edge k+LAT. With LAT=1, ready is seen 2 cycles after req.
- req while busy is ignored. There is no queueing, and the requester must hold req low or re-present the request after ready.
- Back-to-back operation is allowed: req=1 in the cycle after DONE (the FSM is back in IDLE) is accepted.
- Alignment: a halfword requires addr[0]=0; a word requires addr[1:0]=00; a byte is always aligned.
- Misaligned access:
  - No array write occurs and dout is forced to 0.
  - misalign=1 and ready=1 in the DONE cycle; latency is unchanged.
- Byte-lane mapping is little-endian:
  - A byte uses lane addr[1:0], i.e. bits [8*addr[1:0]+7 : 8*addr[1:0]].
  - A halfword uses lanes addr[1]*2 and addr[1]*2+1.
- Store:
  - Only the addressed lanes change; the other lanes keep their value.
  - Word index is addr[ADDR_W-1:2].
- Load: extract the addressed lanes into the low bits of dout, then extend.
  - Sign-extension replicates bit 7 (byte) or bit 15 (halfword).
  - Zero-extension fills the upper bits with 0.
- Address wrap: none is needed, since addr spans exactly the capacity.
- Reset while in WAIT or DONE aborts the access:
  - No write occurs, even if rst coincides with the DONE edge.
  - ready is not pulsed.
  - dout returns to 0.
- The array is read and written only in DONE, so a load issued directly after a store to the same word sees the new data.

Decomposition:
- Package dm_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state encoding (IDLE, WAIT, DONE);
  - function lane_mask(size, addr[1:0]) returning a 4-bit byte-enable.
- Sub-module dm_ram: synchronous 32-bit word array with 4-bit byte-enable write and combinational read.
  - Parameters: depth 2**(ADDR_W-2).
  - dm_sub instantiates it and contains the FSM, alignment check, lane extract and extension logic.

Test Plan:
- Word store then word load: store 0xDEADBEEF at addr 0x010, then load addr 0x010 (LAT=1) -> ready 2 cycles after each req, dout=0xDEADBEEF, misalign=0.
- Byte-store merge: write word 0x11223344 at 0x020, store byte 0xAA at 0x022, load word at 0x020 -> 0x11AA3344.
- Load extension: word 0x000080F0 at 0x030.
  - Load byte at 0x030 with sext=1 -> 0xFFFFFFF0.
  - Load byte at 0x030 with sext=0 -> 0x000000F0.
  - Load halfword at 0x030 with sext=1 -> 0xFFFF80F0.
- Misalignment: halfword store 0xBEEF at 0x041 -> ready with misalign=1. A following word load at 0x040 returns the prior contents unchanged. Word load at 0x042 -> misalign=1, dout=0.
- Latency and busy: LAT=3, req at edge 0 -> busy high for cycles 1..4, ready only in cycle 4. A second req presented in cycle 2 is ignored (only one ready pulse is seen).
- Reset abort: LAT=3, store 0x55 to word 0x050, assert rst in WAIT -> no ready pulse, dout=0. A subsequent load of 0x050 returns the pre-store value.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory unit: access sizes, FSM states and
// the byte-enable / alignment helpers used by dm_sub.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    // Size 2'b11 falls through to the word case everywhere.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << a;
            SZ_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dm_ram.sv
// 32-bit word array with per-byte write enables and an asynchronous read port.
// Contents are deliberately not reset.
module dm_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dm_sub.sv
// Data-memory unit: byte/half/word loads and stores with extension, alignment
// checking and a req/ready handshake with LAT cycles of access latency.
module dm_sub
    import dm_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    output logic              ready,
    output logic [31:0]       dout,
    output logic              busy,
    output logic              misalign
);

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int WA_W  = ADDR_W - 2;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       dout_q;

    logic              we_p0;
    logic [1:0]        size_p0;
    logic              sext_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [31:0]       din_p0;

    logic              mis;
    logic              done;
    logic [31:0]       rdata;
    logic [31:0]       wdata;
    logic [31:0]       ld_val;

    function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [1:0] a, input logic sx);
        logic [31:0] sh;
        sh = word >> {a, 3'b000};
        case (sz)
            SZ_BYTE: extend = {{24{sx & sh[7]}}, sh[7:0]};
            SZ_HALF: extend = {{16{sx & sh[15]}}, sh[15:0]};
            default: extend = word;
        endcase
    endfunction

    // Request capture: data-path registers, loaded only on accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            we_p0   <= we;
            size_p0 <= size;
            sext_p0 <= sext;
            addr_p0 <= addr;
            din_p0  <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dout_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req) cnt <= CNT_W'(LAT - 1);
                WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
                DONE: if (!we_p0 || mis) dout_q <= ld_val;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mis  = misaligned(size_p0, addr_p0[1:0]);
    // A reset landing on the DONE edge must suppress both the write and the pulse.
    assign done = (state == DONE) && !rst;

    always_comb begin
        case (size_p0)
            SZ_BYTE: wdata = {4{din_p0[7:0]}};
            SZ_HALF: wdata = {2{din_p0[15:0]}};
            default: wdata = din_p0;
        endcase
    end

    assign ld_val = mis ? 32'h0 : extend(rdata, size_p0, addr_p0[1:0], sext_p0);

    dm_ram #(
        .DEPTH (2**WA_W),
        .AW    (WA_W)
    ) u_ram (
        .clk   (clk),
        .we    (done && we_p0 && !mis),
        .be    (lane_mask(size_p0, addr_p0[1:0])),
        .addr  (addr_p0[ADDR_W-1:2]),
        .wdata (wdata),
        .rdata (rdata)
    );

    assign ready    = done;
    assign busy     = (state != IDLE);
    assign misalign = done && mis;
    assign dout     = (done && (!we_p0 || mis)) ? ld_val : dout_q;

endmodule
